// File: rtl/reg_scoreboard.sv
// Register scoreboard for an in-order pipeline.
// Tracks one pending-write bit per architectural register, stalls decode on
// RAW/WAW hazards against those bits, and lets a same-cycle writeback release
// the hazard immediately (the register file writes through to the read port).
// A flush from execute cancels the pending bit of the instruction issued in
// the previous cycle. Also reports the number of pending registers and a
// saturating count of stalled cycles.
//
// Handshake: decode presents i_Issue_D with its operands; the instruction is
// accepted on a rising edge where i_Issue_D=1 and o_Stall_D=0, otherwise decode
// must hold it. Writeback and flush are single-cycle pulses, no back-pressure.
module reg_scoreboard #(
  parameter int Address_Width  = 5,
  parameter int Reg_file_Depth = 32,
  parameter int CNT_Width      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_Issue_D,
  input  logic [Address_Width-1:0]  i_RS1_D,
  input  logic [Address_Width-1:0]  i_RS2_D,
  input  logic                      i_Use1_D,
  input  logic                      i_Use2_D,
  input  logic [Address_Width-1:0]  i_Rd_D,
  input  logic                      i_RegWrite_D,
  input  logic                      i_RegWrite_W,
  input  logic [Address_Width-1:0]  i_A3_W,
  input  logic                      i_Flush_E,
  output logic                      o_Stall_D,
  output logic [Reg_file_Depth-1:0] o_Busy,
  output logic [Address_Width:0]    o_Pending,
  output logic [CNT_Width-1:0]      o_StallCnt
);

  localparam int PW = Address_Width + 1;

  logic [Reg_file_Depth-1:0] busy_q, busy_d;
  logic [Reg_file_Depth-1:0] clr;
  logic [Reg_file_Depth-1:0] eb;
  logic [PW-1:0]             pend_q, pend_d;
  logic [CNT_Width-1:0]      cnt_q, cnt_d;
  logic [Address_Width-1:0]  last_rd_q, last_rd_d;
  logic                      last_vld_q, last_vld_d;
  logic                      haz1, haz2, haz3;
  logic                      stall;
  logic                      issue_set;

  // Writeback clear mask; x0 never holds a pending bit so it is never cleared.
  always_comb begin
    clr = '0;
    if (i_RegWrite_W && (i_A3_W != '0)) clr[i_A3_W] = 1'b1;
  end

  assign eb = busy_q & ~clr;

  // Hazard detection: RAW on both sources, WAW on the destination, x0 exempt.
  always_comb begin
    haz1  = i_Use1_D     && (i_RS1_D != '0) && eb[i_RS1_D];
    haz2  = i_Use2_D     && (i_RS2_D != '0) && eb[i_RS2_D];
    haz3  = i_RegWrite_D && (i_Rd_D  != '0) && eb[i_Rd_D];
    stall = rst && i_Issue_D && (haz1 || haz2 || haz3);
    issue_set = i_Issue_D && !stall && i_RegWrite_D && (i_Rd_D != '0);
  end

  assign o_Stall_D = stall;

  // Next busy bitmap: clear on writeback, then flush, then set on issue (set wins).
  always_comb begin
    busy_d = busy_q & ~clr;
    if (i_Flush_E && last_vld_q) busy_d[last_rd_q] = 1'b0;
    if (issue_set) busy_d[i_Rd_D] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Population count of the next bitmap so the count registers alongside it.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < Reg_file_Depth; i++) begin
      pend_d = pend_d + PW'(busy_d[i]);
    end
  end

  // Remember the destination of this cycle's issue for a possible flush next cycle.
  always_comb begin
    last_vld_d = issue_set;
    last_rd_d  = i_Rd_D;
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_Width'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q     <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      last_rd_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      last_rd_q  <= last_rd_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign o_Busy     = busy_q;
  assign o_Pending  = pend_q;
  assign o_StallCnt = cnt_q;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter Address_Width, default 5, register address width.
REQ-002 The block SHALL have parameter Reg_file_Depth, default 32, number of tracked registers (2**Address_Width).
REQ-003 The block SHALL have parameter CNT_Width, default 16, stall counter width.
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port i_Issue_D  input  1  decode holds a valid instruction requesting issue.
REQ-007 The block SHALL have port i_RS1_D / i_RS2_D  input  Address_Width each  source register addresses.
REQ-008 The block SHALL have port i_Use1_D / i_Use2_D  input  1 each  instruction reads RS1 / RS2.
REQ-009 The block SHALL have port i_Rd_D  input  Address_Width  destination register.
REQ-010 The block SHALL have port i_RegWrite_D  input  1  instruction writes Rd.
REQ-011 The block SHALL have port i_RegWrite_W  input  1  writeback retires a register write.
REQ-012 The block SHALL have port i_A3_W  input  Address_Width  writeback destination.
REQ-013 The block SHALL have port i_Flush_E  input  1  cancel the instruction issued in the previous cycle.
REQ-014 The block SHALL have port o_Stall_D  output  1  hold fetch/decode, do not issue.
REQ-015 The block SHALL have port o_Busy  output  Reg_file_Depth  per-register pending-write bitmap.
REQ-016 The block SHALL have port o_Pending  output  Address_Width+1  population count of o_Busy.
REQ-017 The block SHALL have port o_StallCnt  output  CNT_Width  cycles with o_Stall_D high, saturating.

Function
REQ-018 Clear mask: clr = one-hot(i_A3_W) when i_RegWrite_W and i_A3_W != 0, else 0.
REQ-019 Effective busy eb = o_Busy & ~clr (a same-cycle writeback resolves its hazard; Reg_file write-through covers the read).
REQ-020 o_Stall_D SHALL be combinational = i_Issue_D & ((i_Use1_D & eb[RS1]) | (i_Use2_D & eb[RS2]) | (i_RegWrite_D & eb[Rd])), RAW and WAW; any term addressing x0 SHALL be 0.
REQ-021 Issue fires when i_Issue_D & ~o_Stall_D; if also i_RegWrite_D and i_Rd_D != 0, busy[Rd] SHALL be 1 next cycle.
REQ-022 busy[A3] SHALL clear next cycle on clr; if issue sets the same register that cycle, set wins.
REQ-023 The block SHALL record last_rd/last_vld for each issue (last_vld=0 on cycles without a setting issue).
REQ-024 On i_Flush_E with last_vld, busy[last_rd] SHALL clear next cycle; flush has priority over a same-cycle clear, lower than a same-cycle set to the same register.
REQ-025 busy[0] SHALL be constant 0.
REQ-026 o_Pending SHALL be registered, equal to popcount of o_Busy (same cycle, both registered).
REQ-027 o_StallCnt SHALL increment each cycle o_Stall_D=1, holding at all-ones.
REQ-028 Stall latency: hazard visible the cycle after the producer issues; release the same cycle as its writeback.

Reset
REQ-029 When rst=0 at a clock edge: o_Busy=0, o_Pending=0, o_StallCnt=0, last_vld=0; issue, writeback and flush inputs ignored that cycle.
REQ-030 o_Stall_D SHALL be 0 while rst=0; reset mid-stall discards all pending state.

Verification
REQ-031 Issue Rd=5 write, next cycle issue Use1 RS1=5 -> o_Stall_D=1, o_Busy=0x20, o_Pending=1; stays until i_RegWrite_W A3=5, stall drops that same cycle.
REQ-032 Issue Rd=0 write, then RS1=0 -> no stall, o_Busy=0.
REQ-033 Same cycle: issue Rd=7 and writeback A3=7 -> o_Busy[7]=1 next cycle.
REQ-034 Issue Rd=9, next cycle i_Flush_E -> o_Busy[9]=0 following cycle, no stall on RS2=9.
REQ-035 Hold a stall 70000 cycles -> o_StallCnt=0xFFFF; assert rst=0 one cycle -> all outputs 0.
REQ-036 Issue Rd=3,4,5 on consecutive cycles -> o_Pending=3; WAW issue Rd=4 stalls until A3=4 retires.
